hub75_scan_scheduler: RTL and testbench

Sequencer for the HUB75 panel output path. It steps through every scan row and bit-plane, asks the column shifter to load each (row, plane), and then drives the panel address, latch and output-enable. Each plane is lit for a binary-weighted time (binary-coded modulation). It sits between `frame_manager`/`hub75_output` and the panel pins, replacing the ad-hoc `hub75_addr` register in `top_level`.

---
 rtl/hub75_scan_scheduler.sv | 148 ++++++++++++++
 tb/tb_hub75_scan_scheduler.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hub75_scan_scheduler.sv
// hub75_scan_scheduler: walks every (row, bit-plane), requests the column load, then drives
// HUB75 address/latch/OE with binary-weighted lit times. Optional macro: HUB75_SCAN_FRAME_SYNC_EN.
module hub75_scan_scheduler #(
    parameter int SCAN_RATE      = 32,
    parameter int BIT_PLANES     = 3,
    parameter int BASE_OE_CYCLES = 16,
    parameter int BLANK_CYCLES   = 2,
    localparam int ROW_W   = $clog2(SCAN_RATE),
    localparam int PLANE_W = (BIT_PLANES > 1) ? $clog2(BIT_PLANES) : 1,
    localparam int DWELL_W = $clog2(BASE_OE_CYCLES << (BIT_PLANES - 1)) + 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               enable,
    input  logic               frame_start,
    output logic               shift_req,
    output logic [ROW_W-1:0]   shift_row,
    output logic [PLANE_W-1:0] shift_plane,
    input  logic               shift_done,
    output logic [ROW_W-1:0]   hub75_addr,
    output logic               hub75_latch,
    output logic               hub75_OE,
    output logic               frame_done
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_BLANK, S_LATCH, S_DISPLAY} state_t;

    state_t             r_state, w_state_nxt;
    logic [ROW_W-1:0]   r_row, w_row_nxt;
    logic [ROW_W-1:0]   r_addr, w_addr_nxt;
    logic [PLANE_W-1:0] r_plane, w_plane_nxt;
    logic [DWELL_W-1:0] r_dwell, w_dwell_nxt;
    logic               r_shift_req, r_latch, r_oe, r_frame_done;
    logic               w_frame_done_nxt;
    logic               w_sync_pend, w_sync_consume;

`ifdef HUB75_SCAN_FRAME_SYNC_EN
    logic r_sync_pend;

    // A new pulse arriving on the consuming cycle stays pending for the next restart point.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_sync_pend <= 1'b0;
        else        r_sync_pend <= frame_start | (r_sync_pend & ~w_sync_consume);
    end

    assign w_sync_pend = r_sync_pend;
`else
    logic w_unused_sync;
    assign w_sync_pend   = 1'b0;
    assign w_unused_sync = frame_start | w_sync_consume;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_row_nxt        = r_row;
        w_plane_nxt      = r_plane;
        w_addr_nxt       = r_addr;
        w_dwell_nxt      = r_dwell;
        w_frame_done_nxt = 1'b0;
        w_sync_consume   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_sync_pend) begin
                    w_row_nxt      = '0;
                    w_plane_nxt    = '0;
                    w_sync_consume = 1'b1;
                end
                if (enable) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (shift_done) begin
                    w_addr_nxt  = r_row;
                    w_dwell_nxt = DWELL_W'(BLANK_CYCLES - 1);
                    w_state_nxt = S_BLANK;
                end
            end
            S_BLANK: begin
                if (r_dwell == '0) w_state_nxt = S_LATCH;
                else               w_dwell_nxt = r_dwell - 1'b1;
            end
            S_LATCH: begin
                w_dwell_nxt = DWELL_W'((BASE_OE_CYCLES << r_plane) - 1);
                w_state_nxt = S_DISPLAY;
            end
            S_DISPLAY: begin
                if (r_dwell == '0) begin
                    // Plane is the inner loop; a pending frame sync restarts the scan silently.
                    if (w_sync_pend) begin
                        w_row_nxt      = '0;
                        w_plane_nxt    = '0;
                        w_sync_consume = 1'b1;
                    end else if (r_plane != PLANE_W'(BIT_PLANES - 1)) begin
                        w_plane_nxt = r_plane + 1'b1;
                    end else begin
                        w_plane_nxt = '0;
                        if (r_row == ROW_W'(SCAN_RATE - 1)) begin
                            w_row_nxt        = '0;
                            w_frame_done_nxt = 1'b1;
                        end else begin
                            w_row_nxt = r_row + 1'b1;
                        end
                    end
                    w_state_nxt = enable ? S_REQ : S_IDLE;
                end else begin
                    w_dwell_nxt = r_dwell - 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pin-side outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_row        <= '0;
            r_plane      <= '0;
            r_addr       <= '0;
            r_dwell      <= '0;
            r_shift_req  <= 1'b0;
            r_latch      <= 1'b0;
            r_oe         <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_row        <= w_row_nxt;
            r_plane      <= w_plane_nxt;
            r_addr       <= w_addr_nxt;
            r_dwell      <= w_dwell_nxt;
            r_shift_req  <= (w_state_nxt == S_REQ);
            r_latch      <= (w_state_nxt == S_LATCH);
            r_oe         <= (w_state_nxt != S_DISPLAY);
            r_frame_done <= w_frame_done_nxt;
        end
    end

    assign shift_req   = r_shift_req;
    assign shift_row   = r_row;
    assign shift_plane = r_plane;
    assign hub75_addr  = r_addr;
    assign hub75_latch = r_latch;
    assign hub75_OE    = r_oe;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_hub75_scan_scheduler.sv
// Directed bench for hub75_scan_scheduler: SCAN_RATE=4, BIT_PLANES=3, BASE_OE_CYCLES=4, BLANK_CYCLES=2.
module tb_hub75_scan_scheduler;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic       enable;
    logic       frame_start;
    logic       shift_req;
    logic [1:0] shift_row;
    logic [1:0] shift_plane;
    logic       shift_done;
    logic [1:0] hub75_addr;
    logic       hub75_latch;
    logic       hub75_OE;
    logic       frame_done;

    int vectors     = 0;
    int miscompares = 0;

    hub75_scan_scheduler #(
        .SCAN_RATE      (4),
        .BIT_PLANES     (3),
        .BASE_OE_CYCLES (4),
        .BLANK_CYCLES   (2)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .enable      (enable),
        .frame_start (frame_start),
        .shift_req   (shift_req),
        .shift_row   (shift_row),
        .shift_plane (shift_plane),
        .shift_done  (shift_done),
        .hub75_addr  (hub75_addr),
        .hub75_latch (hub75_latch),
        .hub75_OE    (hub75_OE),
        .frame_done  (frame_done)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One (row, plane) transaction: answer the request after k cycles, then measure blank/latch/lit runs.
    task automatic step(input int k, input int er, input int ep, input bit efd,
                        input bit stray, input bit drop_en, input bit fsync);
        int n;
        bit ok;
        n = 0;
        while (shift_req !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("req_seen", shift_req, 1);
        check("req_row", shift_row, er);
        check("req_plane", shift_plane, ep);
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
            tick();
            if (shift_req !== 1'b1 || shift_row !== er[1:0] || shift_plane !== ep[1:0] || hub75_OE !== 1'b1)
                ok = 1'b0;
        end
        shift_done = 1'b1;
        tick();
        shift_done = 1'b0;
        check("req_hold", ok, 1);
        check("req_drop", shift_req, 0);
        n  = 0;
        ok = 1'b1;
        while (hub75_OE === 1'b1 && hub75_latch === 1'b0 && n < 100) begin
            if (hub75_addr !== er[1:0] || frame_done !== 1'b0 || shift_req !== 1'b0) ok = 1'b0;
            n++;
            tick();
        end
        check("blank_len", n, 2);
        n = 0;
        while (hub75_latch === 1'b1 && n < 100) begin
            if (hub75_OE !== 1'b1) ok = 1'b0;
            n++;
            tick();
        end
        check("latch_len", n, 1);
        check("blank_latch_ok", ok, 1);
        n  = 0;
        ok = 1'b1;
        while (hub75_OE === 1'b0 && n < 200) begin
            if (hub75_latch !== 1'b0 || hub75_addr !== er[1:0]) ok = 1'b0;
            shift_done = stray && (n == 1);
            if (fsync) frame_start = (n == 1);
            if (drop_en && n == 3) enable = 1'b0;
            n++;
            tick();
        end
        shift_done  = 1'b0;
        frame_start = 1'b0;
        check("disp_len", n, 4 << ep);
        check("disp_ok", ok, 1);
        check("frame_done", frame_done, efd);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_in      = 1'b1;
        enable      = 1'b0;
        frame_start = 1'b0;
        shift_done  = 1'b0;
        tick();
        tick();
        check("rst_oe", hub75_OE, 1);
        check("rst_req", shift_req, 0);
        check("rst_row", shift_row, 0);
        check("rst_plane", shift_plane, 0);
        check("rst_addr", hub75_addr, 0);
        check("rst_latch", hub75_latch, 0);
        check("rst_fd", frame_done, 0);

        rst_in = 1'b0;
        enable = 1'b1;
        check("idle_req", shift_req, 0);
        tick();
        check("first_req", shift_req, 1);

        // Frame 1: weighting, slow shifter with stray done pulses, wrap
        step(0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(10, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(0,  1, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        step(3,  1, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  2, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  2, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  2, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  3, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  3, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  3, 2, 1'b1, 1'b0, 1'b0, 1'b0);

        // Frame 2: enable drop mid-display of an 8-cycle plane
        step(0,  0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  0, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        check("drop_idle_req", shift_req, 0);
        check("drop_idle_oe", hub75_OE, 1);
        tick();
        tick();
        tick();
        check("drop_idle_hold", shift_req, 0);
        enable = 1'b1;
        tick();
        check("resume_req", shift_req, 1);
        check("resume_row", shift_row, 0);
        check("resume_plane", shift_plane, 2);
        step(0,  0, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  1, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0,  1, 2, 1'b0, 1'b0, 1'b0, 1'b0);

        // frame_start during row 2
        step(0,  2, 0, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef HUB75_SCAN_FRAME_SYNC_EN
        check("sync_row", shift_row, 0);
        check("sync_plane", shift_plane, 0);
`else
        check("sync_row", shift_row, 2);
        check("sync_plane", shift_plane, 1);
`endif

        // Asynchronous reset in the middle of a lit period
        shift_done = 1'b1;
        tick();
        shift_done = 1'b0;
        n = 0;
        while (hub75_OE !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        check("rst_reach_disp", hub75_OE, 0);
        tick();
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_oe", hub75_OE, 1);
        check("arst_req", shift_req, 0);
        check("arst_addr", hub75_addr, 0);
        check("arst_latch", hub75_latch, 0);
        check("arst_row", shift_row, 0);
        enable = 1'b0;
        tick();
        rst_in = 1'b0;
        tick();
        check("post_rst_req", shift_req, 0);
        check("post_rst_oe", hub75_OE, 1);
        tick();
        check("post_rst_idle", shift_req, 0);
        check("post_rst_plane", shift_plane, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
